// File: rtl/hsched_pkg.sv
// Shared state type, default widths and counter-width helper for the
// hilbert_sched sample scheduler.
package hsched_pkg;

  localparam int DEF_DATA_W   = 12;
  localparam int DEF_OUT_W    = 13;
  localparam int DEF_CADENCE  = 20;
  localparam int DEF_FILT_LAT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } hsched_state_t;

  function automatic int cnt_width(input int cadence);
    return (cadence > 1) ? $clog2(cadence) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_CADENCE);

endpackage

// File: rtl/hilbert_sched_if.sv
// Input stream, filter bus and output stream of hilbert_sched.
// The slave modport is the scheduler's own view of these signals.
interface hilbert_sched_if
  import hsched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              filt_en;
  logic [DATA_W-1:0] filt_in;
  logic [OUT_W-1:0]  filt_re;
  logic [OUT_W-1:0]  filt_im;
  logic [OUT_W-1:0]  out_re;
  logic [OUT_W-1:0]  out_im;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data, in_valid, filt_re, filt_im, out_ready,
    output in_ready, filt_en, filt_in, out_re, out_im, out_valid
  );

  modport master (
    output in_data, in_valid, filt_re, filt_im, out_ready,
    input  in_ready, filt_en, filt_in, out_re, out_im, out_valid
  );
endinterface

// File: rtl/hsched_cadence.sv
// Sample-period down-counter: ticks on a zero count while enabled, then
// reloads to CADENCE-1. load forces the count to zero so a run ticks at once.
module hsched_cadence
  import hsched_pkg::*;
#(
  parameter int CADENCE = DEF_CADENCE
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic tick
);
  localparam int CADENCE_W = cnt_width(CADENCE);
  localparam logic [CADENCE_W-1:0] RELOAD = CADENCE_W'(CADENCE - 1);

  logic [CADENCE_W-1:0] cnt_r;

  assign tick = enable && (cnt_r == {CADENCE_W{1'b0}});

  // Cadence counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CADENCE_W{1'b0}};
    end else if (load) begin
      cnt_r <= {CADENCE_W{1'b0}};
    end else if (enable) begin
      cnt_r <= tick ? RELOAD : cnt_r - CADENCE_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/hilbert_sched.sv
// Sample-rate scheduler and result capture for the real2cpx Hilbert filter.
// Build option HSCHED_STATS_EN adds saturating underrun/overrun event counters.
module hilbert_sched
  import hsched_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int CADENCE  = DEF_CADENCE,
  parameter int FILT_LAT = DEF_FILT_LAT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  hilbert_sched_if.slave bus,
  output logic           busy,
  output logic           underrun,
  output logic           overrun
`ifdef HSCHED_STATS_EN
  ,
  output logic [15:0]    under_cnt,
  output logic [15:0]    over_cnt
`endif
);
  localparam int LAT_W = $clog2(FILT_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(FILT_LAT);

  hsched_state_t     state_r, state_nxt_s;
  logic [DATA_W-1:0] buf_r, filt_in_r;
  logic              buf_valid_r, filt_en_r, pend_r, out_valid_r;
  logic [LAT_W-1:0]  lat_r;
  logic [OUT_W-1:0]  out_re_r, out_im_r;
  logic              underrun_r, overrun_r;
  logic              go_s, run_s, tick_s, accept_s, capture_s, starve_s, clobber_s;

  assign go_s      = (state_r == IDLE) && start;
  assign run_s     = (state_r == RUN);
  assign accept_s  = bus.in_valid && !buf_valid_r;
  assign capture_s = pend_r && (lat_r == {LAT_W{1'b0}});
  assign starve_s  = tick_s && !buf_valid_r;
  assign clobber_s = capture_s && out_valid_r && !bus.out_ready;

  hsched_cadence #(.CADENCE(CADENCE)) u_cadence (
    .clock  (clock),
    .reset  (reset),
    .load   (go_s),
    .enable (run_s),
    .tick   (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next state; DRAIN waits for an in-flight capture before idling.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = RUN;   else state_nxt_s = IDLE;
      RUN:     if (stop)  state_nxt_s = DRAIN; else state_nxt_s = RUN;
      DRAIN:   if (!pend_r || capture_s) state_nxt_s = IDLE; else state_nxt_s = DRAIN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Input buffer, filter strobe/sample and filter latency tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_r       <= {DATA_W{1'b0}};
      buf_valid_r <= 1'b0;
      filt_en_r   <= 1'b0;
      filt_in_r   <= {DATA_W{1'b0}};
      pend_r      <= 1'b0;
      lat_r       <= {LAT_W{1'b0}};
    end else begin
      filt_en_r <= tick_s;
      // A sample offered during a starved tick is still taken, just not used.
      if (tick_s && buf_valid_r) begin
        buf_valid_r <= 1'b0;
      end else if (accept_s) begin
        buf_r       <= bus.in_data;
        buf_valid_r <= 1'b1;
      end else begin
        buf_valid_r <= buf_valid_r;
      end
      if (tick_s) filt_in_r <= buf_valid_r ? buf_r : {DATA_W{1'b0}};
      else        filt_in_r <= filt_in_r;
      if (tick_s) begin
        pend_r <= 1'b1;
        lat_r  <= LAT_LOAD;
      end else if (pend_r) begin
        pend_r <= !capture_s;
        lat_r  <= capture_s ? lat_r : lat_r - LAT_W'(1);
      end else begin
        pend_r <= 1'b0;
        lat_r  <= lat_r;
      end
    end
  end

  // Output register with consume-then-load on a coincident capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_re_r    <= {OUT_W{1'b0}};
      out_im_r    <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (capture_s) begin
      out_re_r    <= bus.filt_re;
      out_im_r    <= bus.filt_im;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Sticky fault flags, cleared when a run is started.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else if (go_s) begin
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      underrun_r <= underrun_r | starve_s;
      overrun_r  <= overrun_r | clobber_s;
    end
  end

`ifdef HSCHED_STATS_EN
  logic [15:0] under_cnt_r, over_cnt_r;

  // Saturating event counters, cleared when a run is started.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      under_cnt_r <= 16'd0;
      over_cnt_r  <= 16'd0;
    end else if (go_s) begin
      under_cnt_r <= 16'd0;
      over_cnt_r  <= 16'd0;
    end else begin
      if (starve_s && under_cnt_r != 16'hFFFF) under_cnt_r <= under_cnt_r + 16'd1;
      else                                     under_cnt_r <= under_cnt_r;
      if (clobber_s && over_cnt_r != 16'hFFFF) over_cnt_r <= over_cnt_r + 16'd1;
      else                                     over_cnt_r <= over_cnt_r;
    end
  end

  assign under_cnt = under_cnt_r;
  assign over_cnt  = over_cnt_r;
`endif

  assign bus.in_ready  = !buf_valid_r;
  assign bus.filt_en   = filt_en_r;
  assign bus.filt_in   = filt_in_r;
  assign bus.out_re    = out_re_r;
  assign bus.out_im    = out_im_r;
  assign bus.out_valid = out_valid_r;
  assign busy          = (state_r != IDLE);
  assign underrun      = underrun_r;
  assign overrun       = overrun_r;
endmodule

// File: tb/tb_hilbert_sched.sv
// Bench for hilbert_sched: directed and random stimulus checked every cycle
// against a timeline model (absolute tick/capture cycle numbers).
module tb_hilbert_sched;
  localparam int DATA_W   = 12;
  localparam int OUT_W    = 13;
  localparam int CADENCE  = 20;
  localparam int FILT_LAT = 4;

  logic clock = 1'b0;
  logic reset, start, stop;
  logic busy, underrun, overrun;
`ifdef HSCHED_STATS_EN
  logic [15:0] under_cnt, over_cnt;
`endif
  logic [DATA_W-1:0] d1, d2, d3, d4;

  hilbert_sched_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  hilbert_sched #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CADENCE(CADENCE), .FILT_LAT(FILT_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .bus(bus),
    .busy(busy), .underrun(underrun), .overrun(overrun)
`ifdef HSCHED_STATS_EN
    , .under_cnt(under_cnt), .over_cnt(over_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Stub filter: sign-extended filt_in delayed four clocks, imaginary = negation.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      d1 <= '0; d2 <= '0; d3 <= '0; d4 <= '0;
    end else begin
      d1 <= bus.filt_in; d2 <= d1; d3 <= d2; d4 <= d3;
    end
  end
  assign bus.filt_re = {d4[DATA_W-1], d4};
  assign bus.filt_im = -{d4[DATA_W-1], d4};

  int n_chk, n_err;
  int m_edge, m_state, m_next_tick, m_pend_edge, m_ucnt, m_ocnt;
  bit m_buf_v, m_fen, m_pend, m_ov, m_uf, m_of;
  logic [DATA_W-1:0] m_buf_d, m_fin, m_pend_val;
  logic [OUT_W-1:0]  m_ore, m_oim;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  task automatic model_reset();
    m_state = 0; m_next_tick = 0; m_pend_edge = 0; m_ucnt = 0; m_ocnt = 0;
    m_buf_v = 0; m_fen = 0; m_pend = 0; m_ov = 0; m_uf = 0; m_of = 0;
    m_buf_d = '0; m_fin = '0; m_pend_val = '0; m_ore = '0; m_oim = '0;
  endtask

  // Advance the model across the coming clock edge using the present inputs.
  task automatic model_step();
    bit tick, cap, pend_pre, bufv_pre;
    logic [DATA_W-1:0] issue;
    m_edge++;
    if (!reset) begin
      model_reset();
      return;
    end
    tick     = (m_state == 1) && (m_edge == m_next_tick);
    cap      = m_pend && (m_pend_edge == m_edge);
    pend_pre = m_pend;
    bufv_pre = m_buf_v;
    issue    = m_buf_v ? m_buf_d : '0;
    if (cap) begin
      if (m_ov && !bus.out_ready) begin
        m_of = 1;
        if (m_ocnt < 65535) m_ocnt++;
      end
      m_ov = 1; m_ore = sext(m_pend_val); m_oim = -sext(m_pend_val); m_pend = 0;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 0;
    end
    m_fen = tick;
    if (tick) begin
      m_fin = issue;
      if (!bufv_pre) begin
        m_uf = 1;
        if (m_ucnt < 65535) m_ucnt++;
      end
      m_pend = 1; m_pend_edge = m_edge + 1 + FILT_LAT; m_pend_val = issue;
      m_next_tick = m_edge + CADENCE;
      m_buf_v = 0;
    end
    if (bus.in_valid && !bufv_pre) begin
      m_buf_v = 1; m_buf_d = bus.in_data;
    end
    case (m_state)
      0: if (start) begin
           m_state = 1; m_next_tick = m_edge + 1;
           m_uf = 0; m_of = 0; m_ucnt = 0; m_ocnt = 0;
         end
      1: if (stop) m_state = 2;
      default: if (!pend_pre || cap) m_state = 0;
    endcase
  endtask

  task automatic cmp_all();
    check_val("filt_en",   32'(bus.filt_en),   32'(m_fen));
    check_val("filt_in",   32'(bus.filt_in),   32'(m_fin));
    check_val("in_ready",  32'(bus.in_ready),  32'(!m_buf_v));
    check_val("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check_val("out_re",    32'(bus.out_re),    32'(m_ore));
    check_val("out_im",    32'(bus.out_im),    32'(m_oim));
    check_val("busy",      32'(busy),          32'(m_state != 0));
    check_val("underrun",  32'(underrun),      32'(m_uf));
    check_val("overrun",   32'(overrun),       32'(m_of));
`ifdef HSCHED_STATS_EN
    check_val("under_cnt", 32'(under_cnt),     32'(m_ucnt));
    check_val("over_cnt",  32'(over_cnt),      32'(m_ocnt));
`endif
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 cmp_all();
    cyc();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic wait_fen(input int budget);
    int k = 0;
    while (!bus.filt_en && k < budget) begin cyc(); k++; end
    check_val("fen_seen", 32'(bus.filt_en), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin cyc(); k++; end
    check_val("idle_seen", 32'(busy), 32'd0);
  endtask

  initial begin
    int last_fen, n, fen_cnt, thr;
    bit prev_ov;
    n_chk = 0; n_err = 0; m_edge = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #1 cmp_all();
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    cyc(); cyc();
    reset = 1'b1;

    // Continuous 12'h123 with a ready sink.
    bus.in_data = 12'h123; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc(); cyc();
    pulse_start();
    last_fen = -1; prev_ov = 1'b0;
    repeat (5 * CADENCE) begin
      cyc();
      if (bus.filt_en) begin
        if (last_fen >= 0) check_val("fen_period", 32'(m_edge - last_fen), 32'(CADENCE));
        last_fen = m_edge;
      end
      if (bus.out_valid && !prev_ov) begin
        check_val("cap_delay", 32'(m_edge - last_fen), 32'(FILT_LAT + 1));
        check_val("re_123", 32'(bus.out_re), 32'h0123);
        check_val("im_123", 32'(bus.out_im), 32'h1EDD);
      end
      prev_ov = bus.out_valid;
    end
    check_val("a_underrun", 32'(underrun), 32'd0);
    check_val("a_overrun",  32'(overrun),  32'd0);
    pulse_stop(); wait_idle(2 * CADENCE);

    // Starved start: zero sample and underrun, cleared by the next start.
    do_reset();
    bus.in_valid = 1'b0;
    pulse_start(); wait_fen(CADENCE);
    check_val("starve_in", 32'(bus.filt_in), 32'd0);
    check_val("starve_uf", 32'(underrun), 32'd1);
    pulse_stop(); wait_idle(2 * CADENCE);
    check_val("uf_sticky", 32'(underrun), 32'd1);
    pulse_start();
    check_val("uf_clear", 32'(underrun), 32'd0);
    pulse_stop(); wait_idle(2 * CADENCE);

    // Blocked sink across two captures: overrun, newest result held.
    do_reset();
    bus.in_data = 12'h100; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    cyc(); pulse_start(); wait_fen(CADENCE);
    bus.in_data = 12'h7FF;
    repeat (2 * CADENCE) cyc();
    check_val("ovr_flag", 32'(overrun), 32'd1);
    check_val("ovr_re", 32'(bus.out_re), 32'h07FF);
    check_val("ovr_im", 32'(bus.out_im), 32'h1801);
    bus.out_ready = 1'b1;
    pulse_stop(); wait_idle(2 * CADENCE);

    // Capture coinciding with a consume of the held result.
    do_reset();
    bus.in_data = 12'h055; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    cyc(); pulse_start();
    n = 0;
    while (!(m_pend && m_ov && m_pend_edge == m_edge + 1) && n < 4 * CADENCE) begin cyc(); n++; end
    check_val("coinc_found", 32'(n < 4 * CADENCE), 32'd1);
    bus.out_ready = 1'b1;
    cyc();
    check_val("coinc_ovr", 32'(overrun), 32'd0);
    check_val("coinc_valid", 32'(bus.out_valid), 32'd1);
    pulse_stop(); wait_idle(2 * CADENCE);

    // Stop two clocks after a strobe: drain through the capture, then idle.
    do_reset();
    bus.in_data = 12'h3A5; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc(); pulse_start(); wait_fen(CADENCE);
    cyc(); cyc();
    pulse_stop();
    n = 1;
    while (busy && n < 2 * CADENCE) begin cyc(); n++; end
    check_val("drain_len", 32'(n), 32'd3);
    fen_cnt = 0;
    repeat (2 * CADENCE) begin cyc(); if (bus.filt_en) fen_cnt++; end
    check_val("no_fen_after", 32'(fen_cnt), 32'd0);

    // Asynchronous reset in DRAIN with a capture in flight.
    do_reset();
    bus.in_data = 12'(($urandom)); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc(); pulse_start(); wait_fen(CADENCE);
    pulse_stop(); cyc();
    #2 reset = 1'b0;
    model_reset();
    #1 cmp_all();
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_ready", 32'(bus.in_ready), 32'd1);
    check_val("arst_filt_in", 32'(bus.filt_in), 32'd0);
`ifdef HSCHED_STATS_EN
    check_val("arst_ucnt", 32'(under_cnt), 32'd0);
`endif
    cyc(); cyc();
    reset = 1'b1;
    repeat (2 * CADENCE) cyc();

    // Random traffic, including start+stop together and ignored restarts.
    do_reset();
    repeat (8) begin
      thr = $urandom_range(1, 4);
      start = 1'b1; stop = 1'($urandom_range(0, 1)); cyc(); start = 1'b0; stop = 1'b0;
      repeat ($urandom_range(60, 200)) begin
        bus.in_valid  = ($urandom_range(0, 4) < thr);
        bus.in_data   = 12'($urandom);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        start = ($urandom_range(0, 49) == 0);
        cyc();
        start = 1'b0;
      end
      pulse_stop();
      wait_idle(3 * CADENCE);
      repeat ($urandom_range(0, 5)) cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hilbert_sched.md
Name: hilbert_sched

Overview:
- Sample-rate scheduler and result capture for the real-to-complex Hilbert datapath (`real2cpx`).
- Accepts 12-bit real samples from an upstream valid/ready source, issues one sample to the filter every CADENCE clocks with a one-cycle enable strobe, and captures the filter's 13-bit Re/Im after FILT_LAT clocks into a valid/ready output register.
- Flags underrun (no sample at a tick) and overrun (result not consumed before the next capture).

Parameters:
- DATA_W, 12, real input sample width.
- OUT_W, 13, Re/Im width.
- CADENCE, 20, clocks per sample period; legal range 2..256.
- FILT_LAT, 4, clocks from filt_en to valid filt_re/filt_im; legal range 1..CADENCE-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; IDLE->RUN, clears sticky flags.
- stop  in  1  pulse; RUN->DRAIN.
- in_data  in  DATA_W  signed sample.
- in_valid  in  1  sample offered.
- in_ready  out  1  one-entry input buffer empty.
- filt_en  out  1  one-cycle sample strobe to the filter.
- filt_in  out  DATA_W  sample driven to the filter; held between strobes.
- filt_re  in  OUT_W  filter real output.
- filt_im  in  OUT_W  filter imaginary output.
- out_re  out  OUT_W  captured real result.
- out_im  out  OUT_W  captured imaginary result.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- busy  out  1  state != IDLE.
- underrun  out  1  sticky.
- overrun  out  1  sticky.

Behaviour:
- Reset (async, reset=0) clears every register:
  - State IDLE.
  - filt_en=0, filt_in=0, out_re=0, out_im=0, out_valid=0.
  - Flags=0, input buffer empty (so in_ready=1), cnt=0, capture pending=0.
- Reset mid-operation discards buffered and in-flight samples. No capture follows.
- Input buffer:
  - Loaded when in_valid && in_ready. in_ready = !buf_valid in every state.
  - No bypass: a sample accepted in a tick cycle is not used by that tick.
- FSM has three states: IDLE, RUN, DRAIN.
  - IDLE: start -> RUN with cnt=0, and underrun/overrun cleared. stop is ignored; start wins if both are asserted.
  - RUN:
    - tick = (cnt==0). cnt reloads to CADENCE-1 on tick, otherwise decrements.
    - start is ignored.
    - stop -> DRAIN. A tick in the same cycle is still issued.
  - DRAIN: no further ticks. -> IDLE in the cycle after the pending capture completes, or immediately if none is pending.
- Tick in cycle T:
  - filt_en=1 during T+1 only.
  - If buf_valid: filt_in <= buffer, and the buffer empties.
  - Else: filt_in <= 0 and underrun <= 1.
- Capture:
  - Lat counter starts at the tick. filt_re/filt_im are sampled at the edge ending cycle T+1+FILT_LAT.
  - out_valid=1 from T+2+FILT_LAT.
  - Since FILT_LAT < CADENCE, at most one capture is pending.
- Output handshake:
  - out_valid clears on out_valid && out_ready.
  - Capture while out_valid && !out_ready overwrites the held result and sets overrun.
  - Capture with out_ready=1 in the same cycle is a consume-then-load: no overrun, out_valid stays 1.
- Widths: no arithmetic on data. Results are passed through unmodified.

Optional Feature:
- Macro `HSCHED_STATS_EN`.
- Defined:
  - Adds ports under_cnt (out, 16) and over_cnt (out, 16).
  - Each is a saturating counter of underrun/overrun events, reset to 0 and cleared by start.
  - Saturates at 16'hFFFF.
- Undefined: ports and logic are absent; the sticky flags only.

Decomposition:
- Package hsched_pkg holds:
  - State enum (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
  - CNT_W = $clog2(CADENCE) helper.
  - Default widths.
- One natural sub-module: hsched_cadence.
  - Holds the cadence down-counter and tick generation, with load and enable inputs.
- The FSM, buffer and capture logic stay in the top level.

Test Plan:
Bench uses CADENCE=20, FILT_LAT=4, and a stub filter: filt_re = sign-extended filt_in delayed 4 clocks, filt_im = its negation.
- Start, then feed in_data=12'h123 continuously with out_ready=1:
  - filt_en pulses every 20 clocks.
  - out_re=13'h0123 and out_im=-291, valid 5 clocks after each filt_en.
  - No flags.
- Start with in_valid=0:
  - First tick drives filt_in=0 and underrun=1.
  - A subsequent start clears underrun.
- out_ready=0 across two captures:
  - overrun=1.
  - out_re holds the second sample (e.g. 12'h7FF -> 13'h07FF).
- Capture coincident with out_ready=1 and out_valid=1: overrun stays 0, out_valid stays 1.
- stop asserted 2 clocks after a filt_en:
  - busy stays 1 until the capture 3 clocks later, then IDLE.
  - No further filt_en.
- reset=0 asserted asynchronously mid-DRAIN: all outputs 0 immediately, in_ready=1, no capture follows. With `HSCHED_STATS_EN`, under_cnt reads 0.
